// File: rtl/mano_pkg.sv
// mano_pkg: shared constants for the Mano basic computer control unit.
//   - common-bus source codes (bus_sel_e)
//   - memory-reference opcodes D0..D7 (opcode_e)
//   - register-reference instruction bit positions in IR[11:0]
//   - timing step values T0..T6 of the sequence counter
package mano_pkg;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [2:0] {
        D_AND = 3'd0,
        D_ADD = 3'd1,
        D_LDA = 3'd2,
        D_STA = 3'd3,
        D_BUN = 3'd4,
        D_BSA = 3'd5,
        D_ISZ = 3'd6,
        D_REG = 3'd7   // register-reference (I=0) or I/O (I=1)
    } opcode_e;

    // Register-reference bit positions
    localparam int RB_CLA = 11;
    localparam int RB_CLE = 10;
    localparam int RB_CMA = 9;
    localparam int RB_CME = 8;
    localparam int RB_CIR = 7;
    localparam int RB_CIL = 6;
    localparam int RB_INC = 5;
    localparam int RB_SPA = 4;
    localparam int RB_SNA = 3;
    localparam int RB_SZA = 2;
    localparam int RB_SZE = 1;
    localparam int RB_HLT = 0;

    // Timing steps
    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;

endpackage

// File: rtl/mano_seq_counter.sv
// mano_seq_counter: timing sequence counter SC.
// Ports:
//   clk, rst : clock, synchronous active-high reset (SC <- 0)
//   clr      : SC <- 0 at the edge (higher priority than inc)
//   inc      : SC <- SC + 1 at the edge
//   sc       : current count
module mano_seq_counter #(
    parameter int SC_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [SC_W-1:0] sc
);

    logic [SC_W-1:0] sc_q, sc_d;

    always_comb begin
        sc_d = sc_q;
        if (clr)
            sc_d = '0;
        else if (inc)
            sc_d = sc_q + SC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            sc_q <= '0;
        else
            sc_q <= sc_d;
    end

    assign sc = sc_q;

endmodule

// File: rtl/mano_control_unit.sv
// mano_control_unit: timing and control unit of the Mano basic computer.
// Sequences fetch (T0-T2), decode/indirect (T3) and execute (T3-T6).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : pulse, sets the run flag while halted
//   ir                  : instruction register (valid from T2)
//   ac_sign, ac_zero,
//   dr_zero, e_flag     : datapath status flags
//   bus_sel             : common-bus source (mano_pkg::bus_sel_e codes)
//   mem_read, mem_write : memory strobes
//   ld_*/inc_*          : register load / increment strobes
//   alu_*               : one-hot ALU operation selects
//   sc, running         : debug view of SC and run flag
//   instr_done          : final cycle of each instruction
// All outputs are combinational from state and inputs, forced quiet
// while in reset or halted.
module mano_control_unit
    import mano_pkg::*;
#(
    parameter int   SC_W      = 3,
    parameter logic RESET_RUN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     ir,
    input  logic            ac_sign,
    input  logic            ac_zero,
    input  logic            dr_zero,
    input  logic            e_flag,
    output logic [2:0]      bus_sel,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ld_ar,
    output logic            inc_ar,
    output logic            ld_pc,
    output logic            inc_pc,
    output logic            ld_dr,
    output logic            inc_dr,
    output logic            ld_ir,
    output logic            ld_ac,
    output logic            ld_e,
    output logic            alu_and,
    output logic            alu_add,
    output logic            alu_lda,
    output logic            alu_cla,
    output logic            alu_cle,
    output logic            alu_cma,
    output logic            alu_cme,
    output logic            alu_cir,
    output logic            alu_cil,
    output logic            alu_inc,
    output logic [SC_W-1:0] sc,
    output logic            running,
    output logic            instr_done
);

    logic            run_q, run_d;
    logic            i_q, i_d;
    logic [2:0]      d_q, d_d;
    logic [SC_W-1:0] sc_q;
    logic            sc_clr, sc_inc;
    logic            active, done, bad_sc;
    bus_sel_e        bus_e;
    opcode_e         op;

    assign op = opcode_e'(d_q);

    mano_seq_counter #(.SC_W(SC_W)) u_sc (
        .clk (clk),
        .rst (rst),
        .clr (sc_clr),
        .inc (sc_inc),
        .sc  (sc_q)
    );

    always_comb begin
        active    = run_q & ~rst;
        done      = 1'b0;
        bad_sc    = 1'b0;
        bus_e     = BUS_NONE;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ld_ar     = 1'b0;
        inc_ar    = 1'b0;
        ld_pc     = 1'b0;
        inc_pc    = 1'b0;
        ld_dr     = 1'b0;
        inc_dr    = 1'b0;
        ld_ir     = 1'b0;
        ld_ac     = 1'b0;
        ld_e      = 1'b0;
        alu_and   = 1'b0;
        alu_add   = 1'b0;
        alu_lda   = 1'b0;
        alu_cla   = 1'b0;
        alu_cle   = 1'b0;
        alu_cma   = 1'b0;
        alu_cme   = 1'b0;
        alu_cir   = 1'b0;
        alu_cil   = 1'b0;
        alu_inc   = 1'b0;
        run_d     = run_q;
        i_d       = i_q;
        d_d       = d_q;
        sc_clr    = 1'b0;
        sc_inc    = 1'b0;

        // start only matters while halted; restart always begins at T0
        if (!run_q && start) begin
            run_d  = 1'b1;
            sc_clr = 1'b1;
        end

        if (active) begin
            case (sc_q)
                SC_W'(T0): begin
                    bus_e = BUS_PC;
                    ld_ar = 1'b1;
                end
                SC_W'(T1): begin
                    bus_e    = BUS_MEM;
                    mem_read = 1'b1;
                    ld_ir    = 1'b1;
                    inc_pc   = 1'b1;
                end
                SC_W'(T2): begin
                    bus_e = BUS_IR;
                    ld_ar = 1'b1;
                    d_d   = ir[14:12];
                    i_d   = ir[15];
                end
                SC_W'(T3): begin
                    if (op == D_REG) begin
                        done = 1'b1;
                        if (!i_q) begin
                            // Only the highest-priority set op bit fires
                            if      (ir[RB_CLA]) alu_cla = 1'b1;
                            else if (ir[RB_CLE]) alu_cle = 1'b1;
                            else if (ir[RB_CMA]) alu_cma = 1'b1;
                            else if (ir[RB_CME]) alu_cme = 1'b1;
                            else if (ir[RB_CIR]) alu_cir = 1'b1;
                            else if (ir[RB_CIL]) alu_cil = 1'b1;
                            else if (ir[RB_INC]) alu_inc = 1'b1;
                            ld_ac  = |ir[RB_CLA:RB_INC];
                            ld_e   = |ir[RB_CLA:RB_INC];
                            // Several skip conditions still advance PC once
                            inc_pc = (ir[RB_SPA] & ~ac_sign) | (ir[RB_SNA] & ac_sign) |
                                     (ir[RB_SZA] & ac_zero)  | (ir[RB_SZE] & ~e_flag);
                            if (ir[RB_HLT])
                                run_d = 1'b0;
                        end
                    end else if (i_q) begin
                        // Indirect: AR <- M[AR], no extra cycle
                        bus_e    = BUS_MEM;
                        mem_read = 1'b1;
                        ld_ar    = 1'b1;
                    end
                end
                SC_W'(T4): begin
                    case (op)
                        D_AND, D_ADD, D_LDA, D_ISZ: begin
                            bus_e    = BUS_MEM;
                            mem_read = 1'b1;
                            ld_dr    = 1'b1;
                        end
                        D_STA: begin
                            bus_e     = BUS_AC;
                            mem_write = 1'b1;
                            done      = 1'b1;
                        end
                        D_BUN: begin
                            bus_e = BUS_AR;
                            ld_pc = 1'b1;
                            done  = 1'b1;
                        end
                        D_BSA: begin
                            bus_e     = BUS_PC;
                            mem_write = 1'b1;
                            inc_ar    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                SC_W'(T5): begin
                    case (op)
                        D_AND: begin alu_and = 1'b1; ld_ac = 1'b1; done = 1'b1; end
                        D_ADD: begin alu_add = 1'b1; ld_ac = 1'b1; ld_e = 1'b1; done = 1'b1; end
                        D_LDA: begin alu_lda = 1'b1; ld_ac = 1'b1; done = 1'b1; end
                        D_BSA: begin
                            bus_e = BUS_AR;
                            ld_pc = 1'b1;
                            done  = 1'b1;
                        end
                        D_ISZ: inc_dr = 1'b1;
                        default: ;
                    endcase
                end
                SC_W'(T6): begin
                    if (op == D_ISZ) begin
                        bus_e     = BUS_DR;
                        mem_write = 1'b1;
                        inc_pc    = dr_zero;
                        done      = 1'b1;
                    end
                end
                default: bad_sc = 1'b1;   // out-of-range SC: quiet, resync to T0
            endcase
            sc_clr = done | bad_sc;
            sc_inc = ~(done | bad_sc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= RESET_RUN;
            i_q   <= 1'b0;
            d_q   <= 3'd0;
        end else begin
            run_q <= run_d;
            i_q   <= i_d;
            d_q   <= d_d;
        end
    end

    assign bus_sel    = bus_e;
    assign sc         = sc_q;
    assign running    = run_q;
    assign instr_done = done;

endmodule

// File: tb/tb_mano_control_unit.sv
// Directed bench for mano_control_unit: fetch/decode/execute strobes per
// timing step, skip/priority decode, ISZ, halt/restart and mid-instruction reset.
module tb_mano_control_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] ir;
    logic        ac_sign, ac_zero, dr_zero, e_flag;
    logic [2:0]  bus_sel;
    logic        mem_read, mem_write, ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ir;
    logic        ld_ac, ld_e;
    logic        alu_and, alu_add, alu_lda, alu_cla, alu_cle, alu_cma, alu_cme;
    logic        alu_cir, alu_cil, alu_inc;
    logic [2:0]  sc;
    logic        running, instr_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mano_control_unit dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir),
        .ac_sign(ac_sign), .ac_zero(ac_zero), .dr_zero(dr_zero), .e_flag(e_flag),
        .bus_sel(bus_sel), .mem_read(mem_read), .mem_write(mem_write),
        .ld_ar(ld_ar), .inc_ar(inc_ar), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .ld_dr(ld_dr), .inc_dr(inc_dr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_e(ld_e),
        .alu_and(alu_and), .alu_add(alu_add), .alu_lda(alu_lda), .alu_cla(alu_cla),
        .alu_cle(alu_cle), .alu_cma(alu_cma), .alu_cme(alu_cme), .alu_cir(alu_cir),
        .alu_cil(alu_cil), .alu_inc(alu_inc), .sc(sc), .running(running),
        .instr_done(instr_done)
    );

    // Flattened view of every control output
    logic [24:0] sig;
    assign sig = {bus_sel, mem_read, mem_write, ld_ar, inc_ar, ld_pc, inc_pc, ld_dr,
                  inc_dr, ld_ir, ld_ac, ld_e, alu_and, alu_add, alu_lda, alu_cla,
                  alu_cle, alu_cma, alu_cme, alu_cir, alu_cil, alu_inc, instr_done};

    localparam logic [24:0] B_AR  = 25'd1 << 22;
    localparam logic [24:0] B_PC  = 25'd2 << 22;
    localparam logic [24:0] B_DR  = 25'd3 << 22;
    localparam logic [24:0] B_AC  = 25'd4 << 22;
    localparam logic [24:0] B_IR  = 25'd5 << 22;
    localparam logic [24:0] B_MEM = 25'd7 << 22;
    localparam logic [24:0] RD    = 25'd1 << 21;
    localparam logic [24:0] WR    = 25'd1 << 20;
    localparam logic [24:0] LAR   = 25'd1 << 19;
    localparam logic [24:0] IAR   = 25'd1 << 18;
    localparam logic [24:0] LPC   = 25'd1 << 17;
    localparam logic [24:0] IPC   = 25'd1 << 16;
    localparam logic [24:0] LDR   = 25'd1 << 15;
    localparam logic [24:0] IDR   = 25'd1 << 14;
    localparam logic [24:0] LIR   = 25'd1 << 13;
    localparam logic [24:0] LAC   = 25'd1 << 12;
    localparam logic [24:0] LE    = 25'd1 << 11;
    localparam logic [24:0] A_AND = 25'd1 << 10;
    localparam logic [24:0] A_ADD = 25'd1 << 9;
    localparam logic [24:0] A_LDA = 25'd1 << 8;
    localparam logic [24:0] A_CLA = 25'd1 << 7;
    localparam logic [24:0] A_CIR = 25'd1 << 3;
    localparam logic [24:0] DONE  = 25'd1 << 0;
    localparam logic [24:0] NONE  = 25'd0;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [24:0] e, input logic [2:0] esc);
        #1;
        total++;
        assert (sig === e) else begin
            bad++;
            $error("FAIL %s strobes got=%h exp=%h", tag, sig, e);
        end
        total++;
        assert (sc === esc) else begin
            bad++;
            $error("FAIL %s sc got=%0d exp=%0d", tag, sc, esc);
        end
    endtask

    task automatic chk_run(input string tag, input logic e);
        total++;
        assert (running === e) else begin
            bad++;
            $error("FAIL %s running got=%b exp=%b", tag, running, e);
        end
    endtask

    // T0..T2 fetch; leaves the bench at T3 of instruction v
    task automatic fetch(input string tag, input logic [15:0] v);
        ir = v;
        chk({tag, "_t0"}, B_PC | LAR, 3'd0);
        cyc;
        chk({tag, "_t1"}, B_MEM | RD | LIR | IPC, 3'd1);
        cyc;
        chk({tag, "_t2"}, B_IR | LAR, 3'd2);
        cyc;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ir = 16'h0000;
        ac_sign = 1'b0; ac_zero = 1'b0; dr_zero = 1'b0; e_flag = 1'b0;
        chk("in_reset", NONE, sc);
        cyc;
        chk("after_reset", NONE, 3'd0);
        chk_run("reset_run", 1'b0);
        rst = 1'b0;
        chk("halted", NONE, 3'd0);

        start = 1'b1;
        chk("start_halted", NONE, 3'd0);
        cyc;
        start = 1'b0;
        chk_run("started", 1'b1);

        // CLA
        fetch("cla", 16'h7800);
        chk("cla_t3", A_CLA | LAC | LE | DONE, 3'd3);
        cyc;

        // ADD direct
        fetch("add", 16'h1123);
        chk("add_t3", NONE, 3'd3);
        cyc;
        chk("add_t4", B_MEM | RD | LDR, 3'd4);
        cyc;
        chk("add_t5", A_ADD | LAC | LE | DONE, 3'd5);
        cyc;

        // ADD indirect
        fetch("addi", 16'h9123);
        chk("addi_t3", B_MEM | RD | LAR, 3'd3);
        cyc;
        chk("addi_t4", B_MEM | RD | LDR, 3'd4);
        cyc;
        chk("addi_t5", A_ADD | LAC | LE | DONE, 3'd5);
        cyc;

        // ISZ, DR becomes zero -> skip
        fetch("isz1", 16'h6050);
        chk("isz1_t3", NONE, 3'd3);
        cyc;
        chk("isz1_t4", B_MEM | RD | LDR, 3'd4);
        cyc;
        chk("isz1_t5", IDR, 3'd5);
        cyc;
        dr_zero = 1'b1;
        chk("isz1_t6", B_DR | WR | IPC | DONE, 3'd6);
        cyc;
        dr_zero = 1'b0;

        // ISZ, DR nonzero -> no skip
        fetch("isz0", 16'h6050);
        cyc; cyc; cyc;
        chk("isz0_t6", B_DR | WR | DONE, 3'd6);
        cyc;

        // CLA|CMA|SPA with AC positive: CLA only, skip taken
        fetch("multi", 16'h7A10);
        chk("multi_t3", A_CLA | LAC | LE | IPC | DONE, 3'd3);
        cyc;

        // SPA with AC negative: no skip; CIR
        ac_sign = 1'b1;
        fetch("spa_neg", 16'h7010);
        chk("spa_neg_t3", DONE, 3'd3);
        cyc;
        ac_sign = 1'b0;
        fetch("cir", 16'h7080);
        chk("cir_t3", A_CIR | LAC | LE | DONE, 3'd3);
        cyc;

        // STA, BUN, BSA, I/O
        fetch("sta", 16'h3010);
        cyc;
        chk("sta_t4", B_AC | WR | DONE, 3'd4);
        cyc;
        fetch("bun", 16'h4010);
        cyc;
        chk("bun_t4", B_AR | LPC | DONE, 3'd4);
        cyc;
        fetch("bsa", 16'h5010);
        cyc;
        chk("bsa_t4", B_PC | WR | IAR, 3'd4);
        cyc;
        chk("bsa_t5", B_AR | LPC | DONE, 3'd5);
        cyc;
        fetch("io", 16'hF800);
        chk("io_t3", DONE, 3'd3);
        cyc;

        // HLT with start in the same cycle: halt wins
        fetch("hlt", 16'h7001);
        start = 1'b1;
        chk("hlt_t3", DONE, 3'd3);
        cyc;
        start = 1'b0;
        chk_run("halted_after_hlt", 1'b0);
        chk("hlt_quiet", NONE, 3'd0);
        cyc; cyc;
        chk("hlt_still_quiet", NONE, 3'd0);

        // restart, then reset during T5 of LDA
        start = 1'b1;
        cyc;
        start = 1'b0;
        chk_run("restarted", 1'b1);
        fetch("lda", 16'h2010);
        cyc;
        chk("lda_t4", B_MEM | RD | LDR, 3'd4);
        cyc;
        rst = 1'b1;
        chk("rst_t5", NONE, 3'd5);
        cyc;
        rst = 1'b0;
        chk("rst_after", NONE, 3'd0);
        chk_run("rst_run", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mano_control_unit.md
Name: mano_control_unit

Overview:
- Timing and control unit for the Mano basic computer.
- Sequences fetch, decode, indirect and execute phases with a sequence counter (SC, T0..T6).
- Drives common-bus select, register load/increment strobes, memory read/write and the one-hot ALU operation selects (AND, ADD, LDA, CLA, CLE, CMA, CME, CIR, CIL, INC).
- Sits between the IR/flag outputs of the datapath and the ALU/register file.

Parameters:
- SC_W, 3, sequence counter width (T0..T6 used).
- RESET_RUN, 0, value of the run flag after reset (1 = fetch immediately).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; sets run flag when halted.
- ir  in  16  instruction register contents (valid from T2).
- ac_sign  in  1  AC[15].
- ac_zero  in  1  AC == 0.
- dr_zero  in  1  DR == 0.
- e_flag  in  1  E register.
- bus_sel  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
- mem_read  out  1  memory drives bus.
- mem_write  out  1  M[AR] <- bus at edge.
- ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ir  out  1 each  register strobes.
- ld_ac  out  1  AC <- alu_out.
- ld_e  out  1  E <- E_out.
- alu_and, alu_add, alu_lda, alu_cla, alu_cle, alu_cma, alu_cme, alu_cir, alu_cil, alu_inc  out  1 each  one-hot ALU selects, at most one high.
- sc  out  SC_W  current timing step (debug).
- running  out  1  run flag.
- instr_done  out  1  high in final cycle of each instruction.

Behaviour:
- State:
  - SC counter.
  - run flag.
  - i_reg: indirect bit.
  - d_reg: 3-bit opcode.
- All outputs are combinational from state and inputs.
- When rst=1 or run=0, all strobes and ALU selects are 0 and bus_sel=0.
- Reset: SC=0, i_reg=0, d_reg=0, run=RESET_RUN. Reset mid-instruction abandons the instruction with no further strobes.
- start while run=0: run=1 next cycle, SC=0. Ignored while running.
- T0: bus_sel=PC, ld_ar.
- T1: mem_read, bus_sel=7, ld_ir, inc_pc.
- T2: bus_sel=IR, ld_ar. Latch d_reg=ir[14:12], i_reg=ir[15].
- T3, by decode:
  - D7 & ~I (register-reference), using ir[11:0]:
    - ALU ops by priority bit11 CLA > 10 CLE > 9 CMA > 8 CME > 7 CIR > 6 CIL > 5 INC.
    - Only the highest set bit is selected; it asserts ld_ac and ld_e.
    - Skips: inc_pc (single) if any of bit4&~ac_sign, bit3&ac_sign, bit2&ac_zero, bit1&~e_flag.
    - bit0 HLT: run=0.
    - SC=0, instr_done.
  - D7 & I (I/O): NOP. SC=0, instr_done.
  - ~D7 & I: mem_read, bus_sel=7, ld_ar.
  - ~D7 & ~I: no strobes.
- Memory-reference execute:
  - AND/ADD/LDA (D0/D1/D2):
    - T4: mem_read, bus_sel=7, ld_dr.
    - T5: alu_and/alu_add/alu_lda, ld_ac.
    - ADD also ld_e.
    - done at T5.
  - STA (D3): T4 bus_sel=AC, mem_write; done.
  - BUN (D4): T4 bus_sel=AR, ld_pc; done.
  - BSA (D5):
    - T4: bus_sel=PC, mem_write, inc_ar.
    - T5: bus_sel=AR, ld_pc; done.
  - ISZ (D6):
    - T4: mem_read, bus_sel=7, ld_dr.
    - T5: inc_dr.
    - T6: bus_sel=DR, mem_write; inc_pc if dr_zero; done.
- Done cycle: SC=0 at the edge; otherwise SC increments.
- Latency in cycles:
  - register-ref/IO: 4.
  - STA/BUN: 5.
  - AND/ADD/LDA/BSA: 6.
  - ISZ: 7.
  - Indirect adds no cycles.
- SC value outside 0..6 while running: all strobes 0, SC=0 next cycle.
- HLT and start in the same cycle: HLT wins.

Decomposition:
- Package mano_pkg holds:
  - bus_sel codes.
  - opcode constants D0..D7.
  - register-reference bit positions.
  - SC step constants T0..T6.
- Sub-module mano_seq_counter: SC with synchronous clr/inc/rst.

Test Plan:
- rst, start, ir=0x7800 (CLA) -> T0..T3 strobes as specified; alu_cla+ld_ac at T3; instr_done at T3; SC returns 0.
- ir=0x1123 (ADD direct) -> T4 mem_read/ld_dr, T5 alu_add+ld_ac+ld_e, done at T5 (6 cycles).
- ir=0x9123 (ADD indirect) -> T3 mem_read+ld_ar, same execute timing, still 6 cycles.
- ir=0x6050 (ISZ):
  - dr_zero=1 at T6 -> mem_write+inc_pc, 7 cycles.
  - dr_zero=0 -> no inc_pc.
- ir=0x7A10 (CLA|CMA|SPA), ac_sign=0 -> only alu_cla asserted, inc_pc=1.
- ir=0x7001 (HLT) with start same cycle -> running=0, all strobes 0. Later start -> T0 fetch resumes. rst asserted at T5 -> strobes 0, SC=0.
